// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point helpers for the layer blocks: activation codes, node FSM states,
// round-half-up arithmetic shift and 8-bit saturation.
package nn_fixed_pkg;

    localparam logic ACT_RELU   = 1'b0;
    localparam logic ACT_LINEAR = 1'b1;

    typedef enum logic [1:0] {StIdle, StMac, StPost, StOut} state_e;

    // Works at 64 bits so adding the rounding constant can never overflow the accumulator width.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                       input int unsigned sh);
        logic signed [63:0] half;
        half = 64'sd1 <<< (sh - 1);
        return (v + half) >>> sh;
    endfunction

    function automatic logic [7:0] sat8(input logic signed [63:0] v, input logic relu);
        logic [7:0] r;
        if (v > 64'sd127) begin
            r = 8'h7f;
        end else if (relu && (v < 64'sd0)) begin
            r = 8'h00;
        end else if (v < -64'sd128) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/node_mac_seq_if.sv
// Streaming input, config write port and streaming output of one neuron node.
interface node_mac_seq_if #(
    parameter int unsigned N_IN = 15
);
    localparam int unsigned AW = $clog2(N_IN + 1);

    logic              in_valid;
    logic              in_ready;
    logic [8*N_IN-1:0] in_data;
    logic              act_mode;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [15:0]       cfg_data;
    logic              cfg_ready;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;

    modport master (
        output in_valid, in_data, act_mode, cfg_we, cfg_addr, cfg_data, out_ready,
        input  in_ready, cfg_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, act_mode, cfg_we, cfg_addr, cfg_data, out_ready,
        output in_ready, cfg_ready, out_valid, out_data
    );

endinterface

// File: rtl/node_act_quant.sv
// Combinational post-processing: round/shift the accumulator, then ReLU or linear
// activation with saturation to a signed byte.
module node_act_quant
    import nn_fixed_pkg::*;
#(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned SHIFT = 6
) (
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic                    i_act_mode,
    output logic [7:0]              o_data
);

    logic signed [63:0] w_acc_ext;
    logic signed [63:0] w_shifted;

    always_comb begin
        w_acc_ext = 64'(i_acc);
        w_shifted = round_shift(w_acc_ext, SHIFT);
        o_data    = sat8(w_shifted, i_act_mode == ACT_RELU);
    end

endmodule

// File: rtl/node_mac_seq.sv
// Time-multiplexed neuron: one signed 8x8 multiplier accumulates N_IN products onto the
// bias, then quantises through node_act_quant. Weights and bias are runtime-loadable.
module node_mac_seq
    import nn_fixed_pkg::*;
#(
    parameter int unsigned N_IN  = 15,
    parameter int unsigned SHIFT = 6,
    parameter int unsigned ACC_W = 24
) (
    input logic           i_clk,
    input logic           i_reset,
    node_mac_seq_if.slave bus
);

    localparam int unsigned AW = $clog2(N_IN + 1);
    localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    state_e                   r_state;
    state_e                   w_state_next;
    logic [IW-1:0]            r_idx;
    logic signed [7:0]        r_w  [N_IN];
    logic signed [7:0]        r_wk [N_IN];
    logic signed [7:0]        r_a  [N_IN];
    logic signed [15:0]       r_bias;
    logic                     r_mode;
    logic signed [ACC_W-1:0]  r_acc;
    logic [7:0]               r_out;
    logic                     r_out_valid;

    logic                     w_in_fire;
    logic                     w_cfg_fire;
    logic                     w_last;
    logic signed [15:0]       w_prod;
    logic [7:0]               w_quant;

    assign bus.in_ready  = (r_state == StIdle) && !i_reset;
    assign bus.cfg_ready = (r_state == StIdle) && !i_reset;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out;

    assign w_in_fire  = bus.in_valid && bus.in_ready;
    assign w_cfg_fire = bus.cfg_we && bus.cfg_ready;
    assign w_last     = (r_idx == IW'(N_IN - 1));
    assign w_prod     = 16'(r_a[r_idx]) * 16'(r_wk[r_idx]);

    node_act_quant #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_act_quant (
        .i_acc      (r_acc),
        .i_act_mode (r_mode),
        .o_data     (w_quant)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_in_fire) w_state_next = StMac;
            StMac:   if (w_last) w_state_next = StPost;
            StPost:  w_state_next = StOut;
            StOut:   if (bus.out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Weights are snapshotted at the handshake so a same-cycle config write only
    // affects later vectors.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx       <= '0;
            r_bias      <= '0;
            r_mode      <= 1'b0;
            r_acc       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < int'(N_IN); i++) begin
                r_w[i]  <= '0;
                r_wk[i] <= '0;
                r_a[i]  <= '0;
            end
        end else begin
            if (w_cfg_fire) begin
                if (bus.cfg_addr < AW'(N_IN)) begin
                    r_w[bus.cfg_addr[IW-1:0]] <= bus.cfg_data[7:0];
                end else if (bus.cfg_addr == AW'(N_IN)) begin
                    r_bias <= bus.cfg_data;
                end
            end
            unique case (r_state)
                StIdle: begin
                    if (w_in_fire) begin
                        for (int i = 0; i < int'(N_IN); i++) begin
                            r_a[i]  <= bus.in_data[8*i +: 8];
                            r_wk[i] <= r_w[i];
                        end
                        r_mode <= bus.act_mode;
                        r_acc  <= ACC_W'(r_bias);
                        r_idx  <= '0;
                    end
                end
                StMac: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    r_idx <= r_idx + IW'(1);
                end
                StPost: begin
                    r_out       <= w_quant;
                    r_out_valid <= 1'b1;
                end
                StOut: begin
                    if (bus.out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_node_mac_seq.sv
// Directed bench for node_mac_seq (N_IN=4, SHIFT=6): table of config/input/expected
// records plus hand-written backpressure, config-collision and mid-MAC reset sequences.
module tb_node_mac_seq;
    import nn_fixed_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned NV = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    node_mac_seq_if #(.N_IN(N)) bus ();

    node_mac_seq #(
        .N_IN  (N),
        .SHIFT (6),
        .ACC_W (24)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    typedef struct packed {
        logic [31:0] w;
        logic [15:0] bias;
        logic [31:0] a;
        logic        mode;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [NV];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic [31:0] w, input logic [15:0] bias,
                                input logic [31:0] a, input logic mode, input logic [7:0] exp);
        vec_t v;
        v.w = w; v.bias = bias; v.a = a; v.mode = mode; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
    endtask

    task automatic load_cfg(input logic [31:0] w, input logic [15:0] bias);
        for (int j = 0; j < 4; j++) cfg_write(3'(j), {8'h00, w[8*j +: 8]});
        cfg_write(3'd4, bias);
    endtask

    task automatic start_vec(input string name, input logic [31:0] a, input logic mode);
        @(negedge clk);
        bus.in_data  = a;
        bus.act_mode = mode;
        bus.in_valid = 1'b1;
        check({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Out_valid must first appear on the 6th cycle after the handshake cycle.
    task automatic wait_out(input string name, input logic [7:0] exp);
        int k;
        bit got;
        k = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (bus.out_valid) got = 1'b1;
        end
        check({name, " latency"}, 32'(k), 32'd6);
        check({name, " out_data"}, 32'(bus.out_data), 32'(exp));
    endtask

    task automatic release_out(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check({name, " out_valid cleared"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        vecs[0]  = mk(32'h04030201, 16'h0000, 32'h40404040, ACT_RELU,   8'h0a);
        vecs[1]  = mk(32'hfcfdfeff, 16'h0000, 32'h40404040, ACT_RELU,   8'h00);
        vecs[2]  = mk(32'hfcfdfeff, 16'h0000, 32'h40404040, ACT_LINEAR, 8'hf6);
        vecs[3]  = mk(32'h7f7f7f7f, 16'h0000, 32'h7f7f7f7f, ACT_RELU,   8'h7f);
        vecs[4]  = mk(32'h7f7f7f7f, 16'h0000, 32'h7f7f7f7f, ACT_LINEAR, 8'h7f);
        vecs[5]  = mk(32'h00000001, 16'h0000, 32'h00000020, ACT_RELU,   8'h01);
        vecs[6]  = mk(32'h00000001, 16'h0000, 32'h0000001f, ACT_RELU,   8'h00);
        vecs[7]  = mk(32'h00000078, 16'h0000, 32'h00000044, ACT_RELU,   8'h7f);
        vecs[8]  = mk(32'h00000078, 16'h0000, 32'h00000044, ACT_LINEAR, 8'h7f);
        vecs[9]  = mk(32'h00000001, 16'h0000, 32'h000000e0, ACT_LINEAR, 8'h00);
        vecs[10] = mk(32'h00000000, 16'hfc00, 32'h40404040, ACT_LINEAR, 8'hf0);
        vecs[11] = mk(32'h00000000, 16'hfc00, 32'h40404040, ACT_RELU,   8'h00);
        vecs[12] = mk(32'h7f7f7f7f, 16'h0000, 32'h80808080, ACT_LINEAR, 8'h80);
        vecs[13] = mk(32'hf905fd02, 16'h0064, 32'h28e2140a, ACT_LINEAR, 8'hfa);
        vecs[14] = mk(32'hf905fd02, 16'h0064, 32'h28e2140a, ACT_RELU,   8'h00);
        vecs[15] = mk(32'h09070503, 16'h012c, 32'h0604fe0a, ACT_RELU,   8'h06);

        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.act_mode = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready", 32'(bus.in_ready), 32'd0);
        check("reset cfg_ready", 32'(bus.cfg_ready), 32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_data", 32'(bus.out_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", 32'(bus.in_ready), 32'd1);
        check("post-reset cfg_ready", 32'(bus.cfg_ready), 32'd1);

        for (int i = 0; i < int'(NV); i++) begin
            load_cfg(vecs[i].w, vecs[i].bias);
            start_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].mode);
            wait_out($sformatf("vec%0d", i), vecs[i].exp);
            release_out($sformatf("vec%0d", i));
        end

        // Backpressure: output held, config writes dropped.
        load_cfg(32'h04030201, 16'h0000);
        start_vec("bp", 32'h40404040, ACT_RELU);
        wait_out("bp", 8'h0a);
        for (int c = 0; c < 5; c++) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 16'h0064;
            @(posedge clk);
            @(negedge clk);
            check("bp out_data stable", 32'(bus.out_data), 32'h0a);
            check("bp out_valid held", 32'(bus.out_valid), 32'd1);
            check("bp in_ready low", 32'(bus.in_ready), 32'd0);
            check("bp cfg_ready low", 32'(bus.cfg_ready), 32'd0);
        end
        bus.cfg_we = 1'b0;
        release_out("bp");
        start_vec("bp rerun", 32'h40404040, ACT_RELU);
        wait_out("bp rerun", 8'h0a);
        release_out("bp rerun");

        // Out-of-range config addresses are ignored.
        cfg_write(3'd5, 16'h7fff);
        cfg_write(3'd7, 16'h1234);
        start_vec("badaddr", 32'h40404040, ACT_RELU);
        wait_out("badaddr", 8'h0a);
        release_out("badaddr");

        // Same-cycle config write and handshake: vector uses old weight, next uses new.
        @(negedge clk);
        bus.in_data = 32'h40404040; bus.act_mode = ACT_RELU; bus.in_valid = 1'b1;
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 16'h0064;
        check("collide cfg_ready", 32'(bus.cfg_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0; bus.cfg_we = 1'b0;
        wait_out("collide", 8'h0a);
        release_out("collide");
        start_vec("collide next", 32'h40404040, ACT_RELU);
        wait_out("collide next", 8'h6d);
        release_out("collide next");

        // Reset mid-MAC aborts the vector and clears weights.
        start_vec("midreset", 32'h40404040, ACT_RELU);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset in_ready", 32'(bus.in_ready), 32'd0);
        check("midreset cfg_ready", 32'(bus.cfg_ready), 32'd0);
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("midreset no out_valid", 32'(seen), 32'd0);
        check("midreset out_data", 32'(bus.out_data), 32'd0);
        start_vec("after reset", 32'h40404040, ACT_LINEAR);
        wait_out("after reset", 8'h00);
        release_out("after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
